clk_mux_switch_ctrl: RTL and testbench
======================================

CLK_MUX_SWITCH_CTRL -- requirements
Module: clk_mux_switch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of the timeout counter and timeout_i.
REQ-002 SHALL have parameter GUARD_CYCLES, default 4, minimum clk0_i cycles between switch completion and the next request acceptance; legal range 1..255.
REQ-003 SHALL have port clk0_i, input, 1, controller clock (always-running reference clock).
REQ-004 SHALL have port rstn0_i, input, 1, reset: asynchronous, active-low, in clk0_i domain.
REQ-005 SHALL have port req_valid_i, input, 1, switch request valid.
REQ-006 SHALL have port req_sel_i, input, 1, requested source: 0 = clk0, 1 = clk1.
REQ-007 SHALL have port req_ready_o, output, 1, request accepted when req_valid_i & req_ready_o.
REQ-008 SHALL have port timeout_i, input, TIMEOUT_W, switch timeout in clk0_i cycles; 0 disables the timeout.
REQ-009 SHALL have port err_clr_i, input, 1, clears err_o.
REQ-010 SHALL have port clk_selected_i, input, 1, mux status (1 = clk0 fully selected, 0 otherwise), asynchronous to clk0_i.
REQ-011 SHALL have port select_o, output, 1, select to the glitch-free clock mux.
REQ-012 SHALL have port cur_sel_o, output, 1, last confirmed source.
REQ-013 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port err_o, output, 1, sticky timeout flag.

Function
REQ-016 SHALL synchronise clk_selected_i through two clk0_i flops (reset 0) before any use; the synchronised value is sts.
REQ-017 SHALL define reached as (sts == ~select_o).
REQ-018 SHALL implement FSM states INIT, IDLE, WAIT, GUARD.
REQ-019 INIT: SHALL hold select_o=0 and req_ready_o=0; it SHALL go to IDLE on the first cycle with sts=1.
REQ-020 IDLE: SHALL drive req_ready_o=1, combinationally, in this state only.
REQ-021 IDLE, on acceptance with req_sel_i == cur_sel_o: SHALL pulse done_o the next cycle, leave select_o unchanged and go to GUARD.
REQ-022 IDLE, on acceptance with req_sel_i != cur_sel_o: SHALL register select_o <= req_sel_i, clear the counter and go to WAIT.
REQ-023 WAIT: SHALL increment the counter every cycle, saturating at all-ones.
REQ-024 WAIT, when reached: SHALL update cur_sel_o <= select_o, pulse done_o for one cycle and go to GUARD.
REQ-025 WAIT, when timeout_i != 0, the counter == timeout_i-1 and not reached: SHALL restore select_o <= cur_sel_o, set err_o, skip the done_o pulse and go to GUARD.
REQ-026 WAIT, when reached and timeout occur in the same cycle: reached SHALL win.
REQ-027 GUARD: SHALL count GUARD_CYCLES cycles, then go to IDLE.
REQ-028 The counter SHALL be shared between WAIT and GUARD and SHALL be cleared on every state entry.
REQ-029 Requests presented outside IDLE SHALL NOT be accepted; the requester SHALL hold req_valid_i and req_sel_i until accepted.
REQ-030 err_o SHALL be set by timeout and cleared by err_clr_i; a set and a clear in the same cycle SHALL leave err_o set.
REQ-031 err_o SHALL NOT block further requests.
REQ-032 select_o and cur_sel_o SHALL be flop outputs with no combinational path from any input.

Reset
REQ-033 On rstn0_i low, SHALL asynchronously force: state INIT, select_o=0, cur_sel_o=0, err_o=0, done_o=0, busy_o=1, req_ready_o=0, counter=0, sync flops=0.
REQ-034 Reset asserted mid-WAIT SHALL abandon the switch with no done_o pulse; select_o SHALL return to 0.
REQ-035 After deassertion, no request SHALL be accepted until sts=1 has been observed.

Verification
REQ-036 Reset release, clk_selected_i tied to 1 -> req_ready_o=0 for 2 cycles (sync) plus 1 cycle (INIT), then 1; select_o=0.
REQ-037 Request sel=1 accepted, clk_selected_i drops to 0 five cycles later -> select_o=1 the cycle after acceptance, done_o pulses once about 7-8 cycles after acceptance, cur_sel_o=1, req_ready_o returns 4 cycles after done_o.
REQ-038 Request sel=1 with timeout_i=10 and clk_selected_i stuck at 1 -> select_o high for 10 cycles then back to 0, err_o=1, no done_o; err_clr_i pulse -> err_o=0.
REQ-039 Request sel=0 while cur_sel_o=0 -> done_o the next cycle, select_o never toggles, GUARD entered.
REQ-040 timeout_i=0 with clk_selected_i stuck -> WAIT is held for 70000 cycles, the counter saturates without wrapping, no err_o; then release status -> done_o.
REQ-041 rstn0_i asserted 3 cycles into WAIT -> all outputs at reset values immediately (asynchronous), no done_o pulse.

Source files
------------

// File: rtl/clk_mux_switch_ctrl.sv
// clk_mux_switch_ctrl
//   Sequences source switches of a glitch-free clock mux from the always-running
//   clk0_i domain. A request is accepted in IDLE. The controller then drives
//   select_o and waits for the synchronised mux status to confirm the switch.
//   On confirmation it updates cur_sel_o and pulses done_o. If the timeout
//   expires first, it reverts select_o and sets the sticky err_o flag. In both
//   cases a guard interval is enforced before the next request is accepted.
//
// Ports
//   clk0_i          controller clock (reference, always running)
//   rstn0_i         asynchronous active-low reset
//   req_valid_i     switch request valid
//   req_sel_i       requested source (0 = clk0, 1 = clk1)
//   req_ready_o     request accepted when req_valid_i & req_ready_o (IDLE only)
//   timeout_i       switch timeout in clk0_i cycles, 0 disables it
//   err_clr_i       clears err_o (a simultaneous set wins)
//   clk_selected_i  mux status, 1 = clk0 fully selected, asynchronous
//   select_o        select to the clock mux
//   cur_sel_o       last confirmed source
//   busy_o          high in every state except IDLE
//   done_o          one-cycle completion pulse
//   err_o           sticky timeout flag

module clk_mux_switch_ctrl #(
  parameter int unsigned TIMEOUT_W    = 16,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                 clk0_i,
  input  logic                 rstn0_i,
  input  logic                 req_valid_i,
  input  logic                 req_sel_i,
  output logic                 req_ready_o,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 err_clr_i,
  input  logic                 clk_selected_i,
  output logic                 select_o,
  output logic                 cur_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  // The counter is shared by the timeout (TIMEOUT_W bits) and the guard
  // interval (up to 255 cycles), so it must be wide enough for both.
  localparam int unsigned CNT_W = (TIMEOUT_W > 8) ? TIMEOUT_W : 8;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             select_q, select_d;
  logic             cur_sel_q, cur_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       sync_q;

  logic             sts;
  logic             reached;
  logic [CNT_W-1:0] tmo_ext;
  logic             tmo_hit;

  // Two-flop synchroniser for the asynchronous mux status.
  always_ff @(posedge clk0_i or negedge rstn0_i) begin
    if (!rstn0_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], clk_selected_i};
    end
  end

  assign sts = sync_q[1];

  // Status reports "clk0 selected", so the target is reached when it is the
  // inverse of the select we are driving.
  assign reached = (sts == ~select_q);

  assign tmo_ext = CNT_W'(timeout_i);
  assign tmo_hit = (timeout_i != '0) && (cnt_q == (tmo_ext - CNT_ONE));

  // State and output registers.
  always_ff @(posedge clk0_i or negedge rstn0_i) begin
    if (!rstn0_i) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      select_q  <= 1'b0;
      cur_sel_q <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      select_q  <= select_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    select_d  = select_q;
    cur_sel_d = cur_sel_q;
    done_d    = 1'b0;
    // Clear first so that a timeout in the same cycle overrides it.
    err_d     = err_q & ~err_clr_i;

    case (state_q)
      ST_INIT: begin
        if (sts) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_IDLE: begin
        if (req_valid_i) begin
          cnt_d = '0;
          if (req_sel_i == cur_sel_q) begin
            // Already on the requested source: complete immediately.
            done_d  = 1'b1;
            state_d = ST_GUARD;
          end else begin
            select_d = req_sel_i;
            state_d  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        // Confirmation takes priority over a coincident timeout.
        if (reached) begin
          cur_sel_d = select_q;
          done_d    = 1'b1;
          state_d   = ST_GUARD;
          cnt_d     = '0;
        end else if (tmo_hit) begin
          select_d = cur_sel_q;
          err_d    = 1'b1;
          state_d  = ST_GUARD;
          cnt_d    = '0;
        end
      end

      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Ready is a decode of the state register, valid in IDLE only.
  assign req_ready_o = (state_q == ST_IDLE);
  assign select_o    = select_q;
  assign cur_sel_o   = cur_sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_clk_mux_switch_ctrl.sv
// tb_clk_mux_switch_ctrl
//   Self-checking bench for clk_mux_switch_ctrl. A simple clock-mux model
//   feeds clk_selected_i: it follows ~select_o after a chosen delay, or it
//   can be stuck. Each switch transaction is described by a record. The
//   record holds the stimulus plus the expected outcome (completion or
//   timeout) and the number of cycles that outcome takes. The outcome is
//   either written by hand or derived by predict() from the switching rules.

module tb_clk_mux_switch_ctrl;

  localparam int unsigned TIMEOUT_W = 16;
  localparam int          GUARD     = 4;
  localparam int          NEVER     = 1 << 30;

  typedef struct {
    bit sel;
    int t;
    int d;
    bit stuck;
    bit clr;
    bit exp_done;
    int lat;
  } vec_t;

  logic                 clk0_i = 1'b0;
  logic                 rstn0_i;
  logic                 req_valid_i;
  logic                 req_sel_i;
  logic                 req_ready_o;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic                 err_clr_i;
  logic                 clk_selected_i;
  logic                 select_o;
  logic                 cur_sel_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  int   n_chk = 0;
  int   n_err = 0;
  logic cur_m;
  logic err_m;

  bit   stuck;
  int   dly;
  logic hist [0:31];

  clk_mux_switch_ctrl #(
    .TIMEOUT_W   (TIMEOUT_W),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk0_i        (clk0_i),
    .rstn0_i       (rstn0_i),
    .req_valid_i   (req_valid_i),
    .req_sel_i     (req_sel_i),
    .req_ready_o   (req_ready_o),
    .timeout_i     (timeout_i),
    .err_clr_i     (err_clr_i),
    .clk_selected_i(clk_selected_i),
    .select_o      (select_o),
    .cur_sel_o     (cur_sel_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk0_i = ~clk0_i;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One clock, then sample point; the mux model updates here too.
  task automatic step();
    @(posedge clk0_i);
    #1;
    for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = select_o;
    if (!stuck) clk_selected_i = ~hist[dly];
  endtask

  function automatic vec_t predict(input vec_t v, input logic cur);
    vec_t r;
    int   reach;
    int   tmo;
    r = v;
    if (v.sel == cur) begin
      r.exp_done = 1'b1;
      r.lat      = 0;
    end else begin
      reach = v.stuck ? NEVER : v.d + 3;
      tmo   = (v.t == 0) ? NEVER : v.t;
      if (reach <= tmo) begin
        r.exp_done = 1'b1;
        r.lat      = reach;
      end else begin
        r.exp_done = 1'b0;
        r.lat      = tmo;
      end
    end
    return r;
  endfunction

  task automatic reset_seq(input string nm);
    rstn0_i        = 1'b0;
    req_valid_i    = 1'b0;
    err_clr_i      = 1'b0;
    stuck          = 1'b0;
    dly            = 0;
    for (int i = 0; i < 32; i++) hist[i] = 1'b0;
    clk_selected_i = 1'b1;
    step();
    step();
    chk1({nm, "_rst_select"}, select_o, 1'b0);
    chk1({nm, "_rst_cur"}, cur_sel_o, 1'b0);
    chk1({nm, "_rst_busy"}, busy_o, 1'b1);
    chk1({nm, "_rst_done"}, done_o, 1'b0);
    chk1({nm, "_rst_err"}, err_o, 1'b0);
    rstn0_i = 1'b1;
    chk1({nm, "_rel_ready0"}, req_ready_o, 1'b0);
    step();
    chk1({nm, "_rel_ready1"}, req_ready_o, 1'b0);
    step();
    chk1({nm, "_rel_ready2"}, req_ready_o, 1'b0);
    step();
    chk1({nm, "_rel_ready3"}, req_ready_o, 1'b1);
    chk1({nm, "_rel_busy3"}, busy_o, 1'b0);
    chk1({nm, "_rel_select"}, select_o, 1'b0);
    cur_m = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int   w;
    bit   change;
    logic base_err;
    logic exp_sel;
    logic exp_cur;
    logic exp_err;
    bit   exp_busy;
    stuck       = v.stuck;
    dly         = v.d;
    timeout_i   = TIMEOUT_W'(v.t);
    req_sel_i   = v.sel;
    req_valid_i = 1'b1;
    err_clr_i   = v.clr;
    w = 0;
    while (req_ready_o !== 1'b1 && w < 200) begin
      step();
      w++;
    end
    chk1($sformatf("v%0d_ready_wait", id), req_ready_o, 1'b1);
    if (req_ready_o !== 1'b1) begin
      req_valid_i = 1'b0;
      err_clr_i   = 1'b0;
      return;
    end
    step();
    req_valid_i = 1'b0;
    req_sel_i   = 1'($urandom);
    change   = (v.sel != cur_m);
    base_err = v.clr ? 1'b0 : err_m;
    exp_cur  = cur_m;
    exp_err  = base_err;
    for (int k = 0; k <= v.lat + GUARD; k++) begin
      exp_busy = (k < v.lat + GUARD);
      if (!change) exp_sel = cur_m;
      else if (k < v.lat || v.exp_done) exp_sel = v.sel;
      else exp_sel = cur_m;
      exp_cur = (v.exp_done && k >= v.lat) ? v.sel : cur_m;
      exp_err = (!v.exp_done && k >= v.lat) ? 1'b1 : base_err;
      chk1($sformatf("v%0d_done_k%0d", id, k), done_o, (v.exp_done && k == v.lat));
      chk1($sformatf("v%0d_select_k%0d", id, k), select_o, exp_sel);
      chk1($sformatf("v%0d_cur_k%0d", id, k), cur_sel_o, exp_cur);
      chk1($sformatf("v%0d_busy_k%0d", id, k), busy_o, exp_busy);
      chk1($sformatf("v%0d_ready_k%0d", id, k), req_ready_o, !exp_busy);
      chk1($sformatf("v%0d_err_k%0d", id, k), err_o, exp_err);
      if (k == v.lat) err_clr_i = 1'b0;
      if (k < v.lat + GUARD) step();
    end
    cur_m = exp_cur;
    err_m = exp_err;
  endtask

  task automatic gap(input bit do_clr, input int id);
    if (do_clr) begin
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      err_m     = 1'b0;
      chk1($sformatf("g%0d_err_clr", id), err_o, 1'b0);
    end
    repeat (30) step();
    chk1($sformatf("g%0d_idle_ready", id), req_ready_o, 1'b1);
    chk1($sformatf("g%0d_idle_err", id), err_o, err_m);
  endtask

  initial begin
    vec_t tbl [8];
    vec_t v;
    int   cnt;
    bit   seen;

    // {sel, timeout, mux delay, stuck, clr held, expect done, latency}
    tbl[0] = '{1'b1, 0,  5, 1'b0, 1'b0, 1'b1, 8};
    tbl[1] = '{1'b1, 0,  0, 1'b0, 1'b0, 1'b1, 0};
    tbl[2] = '{1'b0, 20, 2, 1'b0, 1'b0, 1'b1, 5};
    tbl[3] = '{1'b0, 7,  1, 1'b0, 1'b0, 1'b1, 0};
    tbl[4] = '{1'b1, 10, 0, 1'b1, 1'b0, 1'b0, 10};
    tbl[5] = '{1'b1, 4,  1, 1'b0, 1'b0, 1'b1, 4};
    tbl[6] = '{1'b0, 3,  1, 1'b0, 1'b1, 1'b0, 3};
    tbl[7] = '{1'b0, 1,  0, 1'b0, 1'b0, 1'b0, 1};

    req_sel_i = 1'b0;
    timeout_i = '0;
    reset_seq("init");

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], i);
      gap(!tbl[i].exp_done, i);
    end

    for (int i = 0; i < 40; i++) begin
      v.sel   = 1'($urandom);
      v.d     = int'($urandom_range(0, 20));
      v.stuck = ($urandom_range(0, 5) == 0);
      v.t     = int'($urandom_range(0, 25));
      if (v.stuck && v.t == 0) v.t = int'($urandom_range(1, 25));
      v.clr   = ($urandom_range(0, 7) == 0);
      v       = predict(v, cur_m);
      run_txn(v, 100 + i);
      gap($urandom_range(0, 3) == 0, 100 + i);
    end

    // Return to clk0 before the reset-in-WAIT sequence.
    if (cur_m == 1'b1) begin
      v = '{1'b0, 0, 3, 1'b0, 1'b0, 1'b0, 0};
      v = predict(v, cur_m);
      run_txn(v, 200);
      gap(1'b1, 200);
    end

    // Reset asserted three cycles into WAIT.
    stuck       = 1'b1;
    timeout_i   = '0;
    req_sel_i   = 1'b1;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk1("rstwait_select_hi", select_o, 1'b1);
    chk1("rstwait_busy_hi", busy_o, 1'b1);
    seen = 1'b0;
    repeat (3) begin
      step();
      if (done_o) seen = 1'b1;
    end
    chk1("rstwait_no_done_before", seen, 1'b0);
    rstn0_i = 1'b0;
    #1;
    chk1("rstwait_async_select", select_o, 1'b0);
    chk1("rstwait_async_cur", cur_sel_o, 1'b0);
    chk1("rstwait_async_busy", busy_o, 1'b1);
    chk1("rstwait_async_ready", req_ready_o, 1'b0);
    chk1("rstwait_async_done", done_o, 1'b0);
    chk1("rstwait_async_err", err_o, 1'b0);
    reset_seq("rstwait");

    // Timeout disabled, status stuck for a long time, then released.
    stuck       = 1'b1;
    dly         = 0;
    timeout_i   = '0;
    req_sel_i   = 1'b1;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk1("sat_select_start", select_o, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (done_o || err_o || !busy_o) seen = 1'b1;
    end
    chk1("sat_no_event_held", seen, 1'b0);
    chk1("sat_select_held", select_o, 1'b1);
    chk1("sat_err_held", err_o, 1'b0);
    stuck          = 1'b0;
    clk_selected_i = 1'b0;
    cnt = 0;
    while (done_o !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    chk1("sat_done_seen", done_o, 1'b1);
    chk1("sat_done_latency3", (cnt == 3), 1'b1);
    chk1("sat_cur_updated", cur_sel_o, 1'b1);
    chk1("sat_err_after", err_o, 1'b0);
    repeat (GUARD) step();
    chk1("sat_ready_after_guard", req_ready_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
